// File: rtl/aes_key_expand_seq_if.sv
// Handshake bundle for the AES key-schedule engine: start/key request side
// and the valid/ready round-key stream towards the round datapath.
interface aes_key_expand_seq_if #(
  parameter int KEY_WIDTH = 128
);
  logic                 start;
  logic [KEY_WIDTH-1:0] key_in;
  logic                 busy;
  logic                 rk_valid;
  logic                 rk_ready;
  logic [127:0]         rk_out;
  logic [3:0]           rk_index;
  logic                 done;

  // Requester / round-key consumer side.
  modport master (
    output start, key_in, rk_ready,
    input  busy, rk_valid, rk_out, rk_index, done
  );

  // Key-schedule engine side.
  modport slave (
    input  start, key_in, rk_ready,
    output busy, rk_valid, rk_out, rk_index, done
  );
endinterface

// File: rtl/aes_key_expand_seq.sv
// Iterative AES key schedule (128/192/256-bit keys), one 32-bit word per
// cycle, emitting each 128-bit round key on a valid/ready stream.
// Optional build macro KEY_EXPAND_ZEROIZE_EN: wipe the key window, assembly
// buffer and rk_out once the final round key has been accepted.
module aes_key_expand_seq #(
  parameter int KEY_WIDTH = 128
) (
  input logic                 clk,
  input logic                 rst,
  aes_key_expand_seq_if.slave bus
);
  localparam int NK = KEY_WIDTH / 32;
  localparam int NR = NK + 6;

  generate
    if (!(KEY_WIDTH == 128 || KEY_WIDTH == 192 || KEY_WIDTH == 256)) begin : g_bad_width
      $error("aes_key_expand_seq: KEY_WIDTH must be 128, 192 or 256");
    end
  endgenerate

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  typedef enum logic [1:0] {IDLE, GEN, OUT} state_t;

  state_t          state;
  // win[0] is w[i-NK] (oldest), win[NK-1] is w[i-1] (newest).
  logic [31:0]     win [NK];
  // First three words of the key being built; the fourth goes straight
  // from the generator into rk_out.
  logic [2:0][31:0] asm_buf;
  logic [5:0]      wcnt;   // word index i
  logic [2:0]      kmod;   // i mod NK, kept as a counter (NK=6 is not a power of 2)
  logic [7:0]      rcon;
  logic [31:0]     t_word;
  logic [31:0]     nword;

  // Next schedule word. While i < NK the window is rotated so the key words
  // stream out of win[0] and the window ends up holding the key again.
  always_comb begin
    t_word = win[NK-1];
    if (kmod == 3'd0)
      t_word = sub_word({win[NK-1][23:0], win[NK-1][31:24]}) ^ {rcon, 24'h0};
    else if (NK == 8 && kmod == 3'd4)
      t_word = sub_word(win[NK-1]);
    if (wcnt < 6'(NK)) nword = win[0];
    else               nword = win[0] ^ t_word;
  end

  // Control FSM, key window, assembly buffer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      for (int j = 0; j < NK; j++) win[j] <= '0;
      asm_buf      <= '0;
      wcnt         <= '0;
      kmod         <= '0;
      rcon         <= '0;
      bus.busy     <= 1'b0;
      bus.rk_valid <= 1'b0;
      bus.rk_out   <= '0;
      bus.rk_index <= '0;
      bus.done     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            for (int j = 0; j < NK; j++) win[j] <= bus.key_in[KEY_WIDTH-1-32*j -: 32];
            wcnt         <= '0;
            kmod         <= '0;
            rcon         <= 8'h01;
            bus.rk_index <= '0;
            bus.busy     <= 1'b1;
            state        <= GEN;
          end
        end
        GEN: begin
          for (int j = 0; j < NK-1; j++) win[j] <= win[j+1];
          win[NK-1] <= nword;
          wcnt      <= wcnt + 6'd1;
          kmod      <= (kmod == 3'(NK-1)) ? 3'd0 : kmod + 3'd1;
          if (wcnt >= 6'(NK) && kmod == 3'd0) rcon <= xtime(rcon);
          case (wcnt[1:0])
            2'd0: asm_buf[0] <= nword;
            2'd1: asm_buf[1] <= nword;
            2'd2: asm_buf[2] <= nword;
            default: begin
              bus.rk_out   <= {asm_buf[0], asm_buf[1], asm_buf[2], nword};
              bus.rk_valid <= 1'b1;
              state        <= OUT;
            end
          endcase
        end
        OUT: begin
          if (bus.rk_ready) begin
            bus.rk_valid <= 1'b0;
            if (bus.rk_index == 4'(NR)) begin
              state    <= IDLE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
`ifdef KEY_EXPAND_ZEROIZE_EN
              for (int j = 0; j < NK; j++) win[j] <= '0;
              asm_buf    <= '0;
              bus.rk_out <= '0;
`endif
            end else begin
              bus.rk_index <= bus.rk_index + 4'd1;
              state        <= GEN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Bench for aes_key_expand_seq: one engine per key size, known-answer table,
// randomized keys/backpressure against a FIPS-197 style reference model whose
// S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_key_expand_seq;
  logic clk, rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  aes_key_expand_seq_if #(.KEY_WIDTH(128)) if0 ();
  aes_key_expand_seq_if #(.KEY_WIDTH(192)) if1 ();
  aes_key_expand_seq_if #(.KEY_WIDTH(256)) if2 ();

  aes_key_expand_seq #(.KEY_WIDTH(128)) u0 (.clk(clk), .rst(rst), .bus(if0));
  aes_key_expand_seq #(.KEY_WIDTH(192)) u1 (.clk(clk), .rst(rst), .bus(if1));
  aes_key_expand_seq #(.KEY_WIDTH(256)) u2 (.clk(clk), .rst(rst), .bus(if2));

  // Per-instance stimulus and observation, keys left-aligned in 256 bits.
  logic         start_a [3];
  logic [255:0] key_a   [3];
  logic         rdy_a   [3];
  logic         vld_a   [3];
  logic         busy_a  [3];
  logic         done_a  [3];
  logic [127:0] out_a   [3];
  logic [3:0]   idx_a   [3];

  assign if0.start = start_a[0];  assign if0.key_in = key_a[0][255 -: 128];  assign if0.rk_ready = rdy_a[0];
  assign if1.start = start_a[1];  assign if1.key_in = key_a[1][255 -: 192];  assign if1.rk_ready = rdy_a[1];
  assign if2.start = start_a[2];  assign if2.key_in = key_a[2];              assign if2.rk_ready = rdy_a[2];
  assign vld_a[0] = if0.rk_valid; assign busy_a[0] = if0.busy; assign done_a[0] = if0.done;
  assign out_a[0] = if0.rk_out;   assign idx_a[0] = if0.rk_index;
  assign vld_a[1] = if1.rk_valid; assign busy_a[1] = if1.busy; assign done_a[1] = if1.done;
  assign out_a[1] = if1.rk_out;   assign idx_a[1] = if1.rk_index;
  assign vld_a[2] = if2.rk_valid; assign busy_a[2] = if2.busy; assign done_a[2] = if2.done;
  assign out_a[2] = if2.rk_out;   assign idx_a[2] = if2.rk_index;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  sbox [256];
  logic [31:0] mw   [64];
  logic [127:0] got [16];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] msub(input logic [31:0] x);
    return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] key, input int nk);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 64; i++) mw[i] = '0;
    for (int i = 0; i < nk; i++) mw[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nk+7); i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t  = msub({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % 8 == 4) begin
        t = msub(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] mkey(input int r);
    if (r > 15 || r < 0) return 'x;
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  // One expansion on instance k. Entered and left at a negedge, so back-to-back
  // calls issue start in the same cycle as the previous done.
  // poke: ec at which a bogus start/key is driven; abort_idx: reset on that key.
  task automatic run_exp(input int k, input logic [255:0] key, input int nk, input int pct,
                         input bit timing, input int poke, input int abort_idx);
    int nr, ec, exp_idx, first_v;
    bit stall, r, v;
    logic [127:0] hout;
    logic [3:0]   hidx;
    nr = nk + 6;
    model_expand(key, nk);
    for (int j = 0; j < 16; j++) got[j] = '0;
    start_a[k] = 1'b1; key_a[k] = key; rdy_a[k] = 1'b0;
    @(negedge clk);
    start_a[k] = 1'b0;
    ec = 0; exp_idx = 0; first_v = -1; stall = 1'b0;
    forever begin
      if (ec > 2000) begin
        chk("timeout", 128'(ec), 128'd0);
        rdy_a[k] = 1'b0; start_a[k] = 1'b0;
        return;
      end
      if (done_a[k]) begin
        chk("done_count", 128'(exp_idx), 128'(nr + 1));
        chk("done_busy", 128'(busy_a[k]), 128'd0);
        chk("done_valid", 128'(vld_a[k]), 128'd0);
        if (timing) chk("done_time", 128'(ec), 128'(5*nr + 5));
`ifdef KEY_EXPAND_ZEROIZE_EN
        chk("idle_zeroized", out_a[k], 128'd0);
`else
        chk("idle_retained", out_a[k], mkey(nr));
`endif
        rdy_a[k] = 1'b0; start_a[k] = 1'b0;
        return;
      end
      chk("busy", 128'(busy_a[k]), 128'd1);
      v = vld_a[k];
      if (v) begin
        if (first_v < 0) begin
          first_v = ec;
          if (timing) chk("first_key_time", 128'(ec), 128'd4);
        end
        if (stall) begin
          chk("hold_out", out_a[k], hout);
          chk("hold_index", 128'(idx_a[k]), 128'(hidx));
        end
        chk("rk_index", 128'(idx_a[k]), 128'(exp_idx));
        chk("rk_out", out_a[k], mkey(exp_idx));
        got[idx_a[k]] = out_a[k];
        if (exp_idx == abort_idx) begin
          rst = 1'b1; rdy_a[k] = 1'b0;
          @(negedge clk);
          chk("abort_valid", 128'(vld_a[k]), 128'd0);
          chk("abort_busy", 128'(busy_a[k]), 128'd0);
          chk("abort_out", out_a[k], 128'd0);
          chk("abort_done", 128'(done_a[k]), 128'd0);
          rst = 1'b0;
          return;
        end
      end else if (stall) begin
        chk("hold_valid", 128'd0, 128'd1);
      end
      r = ($urandom_range(99) < pct);
      rdy_a[k] = r;
      stall = v && !r;
      hout = out_a[k];
      hidx = idx_a[k];
      if (v && r) exp_idx++;
      if (ec == poke) begin
        start_a[k] = 1'b1;
        key_a[k]   = ~key;
      end else begin
        start_a[k] = 1'b0;
      end
      @(negedge clk);
      ec++;
    end
  endtask

  typedef struct {
    string        nm;
    int           k;
    int           nk;
    logic [255:0] key;
    int           idx;
    logic [127:0] rk;
  } vec_t;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  initial begin
    vec_t vt [5];
    logic [255:0] rk;
    vt[0] = '{"kat128_r0",  0, 4, K128, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    vt[1] = '{"kat128_r1",  0, 4, K128, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    vt[2] = '{"kat128_r10", 0, 4, K128, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vt[3] = '{"kat192_r12", 1, 6, K192, 12, 128'he98ba06f448c773c8ecc720401002202};
    vt[4] = '{"kat256_r14", 2, 8, K256, 14, 128'hfe4890d1e6188d0b046df344706c631e};

    build_sbox();
    for (int k = 0; k < 3; k++) begin
      start_a[k] = 1'b0; key_a[k] = '0; rdy_a[k] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_valid", 128'(vld_a[k]), 128'd0);
      chk("reset_busy",  128'(busy_a[k]), 128'd0);
      chk("reset_done",  128'(done_a[k]), 128'd0);
      chk("reset_out",   out_a[k], 128'd0);
      chk("reset_index", 128'(idx_a[k]), 128'd0);
    end
    // start together with reset: reset must win
    start_a[0] = 1'b1; key_a[0] = K128;
    @(negedge clk);
    start_a[0] = 1'b0;
    chk("rst_beats_start", 128'(busy_a[0]), 128'd0);
    rst = 1'b0;
    @(negedge clk);

    // known-answer table, full rate with timing checks
    for (int n = 0; n < 5; n++) begin
      run_exp(vt[n].k, vt[n].key, vt[n].nk, 100, 1'b1, -1, -1);
      chk(vt[n].nm, got[vt[n].idx], vt[n].rk);
    end

    // backpressure on the AES-128 vector
    run_exp(0, K128, 4, 40, 1'b0, -1, -1);
    chk("bp_r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // stray start during GEN and during OUT
    run_exp(0, K128, 4, 100, 1'b1, 2, -1);
    chk("poke_gen_r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_exp(0, K128, 4, 70, 1'b0, 9, -1);
    chk("poke_out_r1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);

    // reset while key 5 is presented, then a clean restart
    run_exp(0, K128, 4, 100, 1'b0, -1, 5);
    run_exp(0, K128, 4, 100, 1'b1, -1, -1);
    chk("restart_r0", got[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

    // random keys, random backpressure, all key sizes
    for (int n = 0; n < 9; n++) begin
      rk = {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
      case (n % 3)
        0: rk = {rk[255:128], 128'h0};
        1: rk = {rk[255:64], 64'h0};
        default: ;
      endcase
      run_exp(n % 3, rk, 4 + 2*(n % 3), $urandom_range(30, 100), 1'b0, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/aes_key_expand_seq.md
Name: aes_key_expand_seq

Overview:
- Iterative AES key-schedule engine. Expands a 128/192/256-bit cipher key into NR+1 128-bit round keys, one 32-bit word per cycle.
- Presents each completed round key on a valid/ready output.
- Sits directly upstream of the encryption round datapath and supplies its key input: round key r feeds round r, and key 0 feeds the initial AddRoundKey.

Parameters:
- KEY_WIDTH, 128, cipher key size in bits. Legal values are 128, 192 and 256; anything else is an elaboration error.
- Derived, not overridable: NK = KEY_WIDTH/32; NR = NK+6; TOTAL_WORDS = 4*(NR+1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to begin an expansion; sampled only in IDLE
- key_in  input  KEY_WIDTH  cipher key; key_in[KEY_WIDTH-1 -: 32] is w[0] (FIPS-197 byte order); sampled with start
- busy  output  1  high from the cycle after start is accepted until the final key is accepted
- rk_valid  output  1  rk_out/rk_index hold a complete round key
- rk_ready  input  1  consumer accepts the key when rk_valid && rk_ready
- rk_out  output  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] at [127:96]
- rk_index  output  4  round number r, range 0..NR
- done  output  1  one-cycle pulse after round key NR is accepted

Behaviour:
- Reset: all outputs 0; FSM in IDLE; word counter, Rcon, key window and assembly buffer cleared. Reset mid-expansion aborts immediately. No partial key is emitted afterwards.
- States: IDLE, GEN, OUT.
- IDLE: on start, latch key_in into an NK-word window. Set word index i=0, Rcon=0x01, rk_index=0. Go to GEN.
- GEN: produce exactly one word per cycle into a 4-word assembly buffer.
  - i < NK: the word is key word i.
  - Otherwise w[i] = w[i-NK] ^ t, where t = w[i-1], except:
    - i mod NK == 0: t = SubWord(RotWord(w[i-1])) ^ {Rcon,24'h0}; after use, Rcon <= xtime(Rcon) (poly 0x11B).
    - NK==8 and i mod 8 == 4: t = SubWord(w[i-1]).
  - SubWord uses the standard AES S-box on 4 bytes. The window shifts by one word per cycle. i increments.
  - After the 4th word of a key, go to OUT.
- OUT:
  - rk_valid=1. rk_out and rk_index stay stable until handshake. Generation stalls: window, i and Rcon are frozen.
  - On rk_valid && rk_ready with rk_index<NR: rk_valid falls next cycle, rk_index++, return to GEN.
  - On handshake with rk_index==NR: go to IDLE; busy=0 and done=1 for one cycle.
- Timing with rk_ready held at 1:
  - start sampled at edge E0; rk_valid for key 0 is high in the cycle after edge E4.
  - Each key is valid for exactly 1 cycle; successive keys are 5 cycles apart.
  - AES-128 completes in 55 cycles after start.
- Sequence: rk_valid low → high only inside an expansion; keys are emitted strictly in order 0..NR with no gaps or repeats.
- start while busy (GEN/OUT) is ignored; the key_in change has no effect.
- start and rst in the same cycle: rst wins.
- rk_ready is ignored when rk_valid=0.
- start in the same cycle as done is accepted (the FSM is already IDLE).
- Words are assembled from key words and derived words without special-casing 192-bit boundary straddle; the same buffer path applies.

Optional Feature:
- Macro: KEY_EXPAND_ZEROIZE_EN.
- Defined: in the cycle after the final handshake (same cycle as done), the key window, assembly buffer and rk_out are cleared to 0. rk_out reads 0 in IDLE after any completed expansion.
- Undefined: in IDLE, rk_out retains the last round key and the window retains the last words.
- Both builds: reset clears everything.

Test Plan:
- KEY_WIDTH=128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 → 11 keys. rk_index 0 = key. rk_index 1 = a0fafe1788542cb123a339392a6c7605. rk_index 10 = d014f9a8c9ee2589e13f0cc8b6630ca6. done 55 cycles after start.
- KEY_WIDTH=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → 13 keys; rk_index 12 = e98ba06f448c773c8ecc720401002202.
- KEY_WIDTH=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → 15 keys; rk_index 14 = fe4890d1e6188d0b046df344706c631e.
- Backpressure: AES-128 vector with rk_ready randomly low (≥50%) → identical 11-key sequence. rk_out/rk_index stable while rk_valid && !rk_ready. No duplicate or skipped index.
- Control corners:
  - start pulsed mid-expansion with a different key → output unchanged from the single-start run.
  - rst asserted while rk_index=5 in OUT → next cycle rk_valid=0, busy=0, rk_out=0.
  - A fresh start then yields the correct key 0 sequence.
- Zeroize: run AES-128 to completion with and without KEY_EXPAND_ZEROIZE_EN → in IDLE, rk_out = 0 (defined) or d014f9a8c9ee2589e13f0cc8b6630ca6 (undefined).
